ex_unit: RTL and testbench
==========================

# ex_unit

Execute stage of the five-stage pipeline. Consumes the decoded operation from the ID/EX register (aluop, alusel, two 32-bit operands, destination register and write enable). Produces the write-back result for EX/MEM and the same-cycle forwarding path back to decode. Logic and shift results are single-cycle; DIV/DIVU run on an iterative 32-step divider that stalls the pipeline and writes HI/LO.

## Interface
Parameters:
- none; widths come from the shared define file (`RegBus` = 32, `RegAddBus` = 5, `AluOpBus` = 8, `AluSelBus` = 3).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  aborts any divide in progress
- aluop_i  in  `AluOpBus`  operation subtype (`EXE_*_OP`)
- alusel_i  in  `AluSelBus`  result class (`EXE_RES_LOGIC` / `EXE_RES_SHIFT` / `EXE_RES_NOP`)
- reg1_i  in  32  source operand 1 (register or immediate)
- reg2_i  in  32  source operand 2
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wd_o  out  5  destination address to EX/MEM and forwarding
- wreg_o  out  1  write enable to EX/MEM and forwarding
- wdata_o  out  32  result to EX/MEM and forwarding
- whilo_o  out  1  HI/LO write strobe, one cycle
- hi_o  out  32  HI value (remainder)
- lo_o  out  32  LO value (quotient)
- stallreq_o  out  1  requests freeze of PC, IF/ID and ID/EX

## Operation
- While rst is high, all outputs are 0 and the divider FSM is in IDLE.
- wd_o = wd_i and wreg_o = wreg_i, both combinational.
- Logic ops: OR, AND, XOR and NOR of reg1_i and reg2_i. Any other aluop gives 0.
- Shift ops: the shift amount is reg1_i[4:0] and the data is reg2_i.
  - SLL is a logical left shift.
  - SRL is a logical right shift.
  - SRA is an arithmetic right shift (sign of reg2_i[31]).
- wdata_o selects by alusel_i: LOGIC gives the logic result, SHIFT gives the shift result, anything else gives 0.
- Divider FSM has three states: IDLE, CALC, DONE.
  - IDLE to CALC: aluop_i is `EXE_DIV_OP` or `EXE_DIVU_OP` and reg2_i != 0.
    - Latch |reg1_i| and |reg2_i| for DIV (raw values for DIVU).
    - Latch the result signs: quotient sign = reg1_i[31] ^ reg2_i[31]; remainder sign = reg1_i[31].
    - Clear the partial remainder and set count = 0.
  - IDLE to DONE: divide op with reg2_i == 0. Latch quotient = 0xFFFFFFFF and remainder = reg1_i.
  - CALC: one restoring step per cycle (shift in a dividend bit, subtract the divisor, keep on non-negative). Go to DONE when count reaches 31.
  - DONE: apply the sign fix (DIV only) and drive hi_o/lo_o. Assert whilo_o for exactly this cycle, then return to IDLE.
- stallreq_o = 1 when a divide op is present and the state is IDLE or CALC; otherwise 0.
- Divide ops never write the GPR file; decode supplies wreg_i = 0.
- flush_i in any state returns the FSM to IDLE next cycle, with no whilo_o and stallreq_o = 0 from that cycle on.
- rst has priority over flush_i.
- hi_o/lo_o are 0 outside DONE.

## Timing
- Logic and shift: zero-cycle combinational. The result is valid in the same cycle as the inputs, so decode forwarding sees it that cycle.
- Divide, nonzero divisor:
  - cycle 0 is the issue cycle (IDLE);
  - cycles 1–32 are CALC;
  - cycle 33 is DONE.
  - stallreq_o is high in cycles 0–32 and low in cycle 33.
  - whilo_o pulses in cycle 33. Total latency is 34 cycles.
- Divide by zero: IDLE then DONE, whilo_o in cycle 1 (2 cycles total).
- Upstream must hold all inputs stable while stallreq_o is high. The FSM only samples the operands in IDLE.
- Back-to-back divides: the IDLE cycle after DONE accepts the next divide.

## Configuration
- `DIV_EN` defined: divider FSM, stall and HI/LO outputs are built.
- Not defined:
  - divide ops are treated as NOP;
  - whilo_o, hi_o, lo_o and stallreq_o are tied to 0;
  - no divider registers are synthesized.

## Test plan
- OR: alusel LOGIC, aluop OR, reg1 0x0000FF00, reg2 0x00F0000F, wd 5, wreg 1 → wdata_o 0x00F0FF0F same cycle, wd_o 5, wreg_o 1.
- SRA: aluop SRA, reg1 0x00000004, reg2 0x80000000 → wdata_o 0xF8000000. SRL with the same operands → 0x08000000.
- DIV: reg1 0xFFFFFFF9 (−7), reg2 2 → stallreq_o high 33 cycles; in DONE lo_o 0xFFFFFFFD (−3), hi_o 0xFFFFFFFF (−1), whilo_o 1 for one cycle.
- DIVU: reg1 100, reg2 7 → in DONE lo_o 14, hi_o 2, cycle 33 after issue.
- Divide by zero: reg1 0x12345678, reg2 0 → next cycle whilo_o 1, lo_o 0xFFFFFFFF, hi_o 0x12345678. stallreq_o low after issue cycle.
- Abort: flush_i at CALC cycle 10 → IDLE next cycle, no whilo_o ever. A rst pulse mid-CALC likewise leaves all outputs 0.

Source files
------------

// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift results with forwarding, plus an optional
// 32-step restoring divider (enabled by defining DIV_EN) that stalls the pipeline and writes HI/LO.
module ex_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [4:0]  shamt;

  assign shamt = reg1_i[4:0];

  always_comb begin
    logic_res = 32'h0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'h0;
    endcase
  end

  always_comb begin
    shift_res = 32'h0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << shamt;
      EXE_SRL_OP: shift_res = reg2_i >> shamt;
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> shamt);
      default:    shift_res = 32'h0;
    endcase
  end

  // Forwarding path is combinational so decode sees the result in the same cycle.
  always_comb begin
    wdata_o = 32'h0;
    if (!rst) begin
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        default:       wdata_o = 32'h0;
      endcase
    end
  end

  assign wd_o   = rst ? 5'd0 : wd_i;
  assign wreg_o = rst ? 1'b0 : wreg_i;

`ifdef DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  div_state_t  state;
  logic [4:0]  count;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic        whilo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        is_div;
  logic        is_signed;
  logic [32:0] rem_shift;
  logic [33:0] diff;
  logic        qbit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

  assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_signed = (aluop_i == EXE_DIV_OP);

  // The dividend register doubles as the quotient: each step shifts one dividend bit
  // out of the top and one quotient bit in at the bottom.
  always_comb begin
    rem_shift = {rem, dvd[31]};
    diff      = {1'b0, rem_shift} - {2'b00, dvs};
    qbit      = ~diff[33];
    rem_next  = qbit ? diff[31:0] : rem_shift[31:0];
    quo_next  = {dvd[30:0], qbit};
    quo_fix   = q_neg ? (32'h0 - quo_next) : quo_next;
    rem_fix   = r_neg ? (32'h0 - rem_next) : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 5'd0;
      dvd     <= 32'h0;
      dvs     <= 32'h0;
      rem     <= 32'h0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      whilo_r <= 1'b0;
      hi_r    <= 32'h0;
      lo_r    <= 32'h0;
    end else if (flush_i) begin
      state   <= IDLE;
      whilo_r <= 1'b0;
      hi_r    <= 32'h0;
      lo_r    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          whilo_r <= 1'b0;
          hi_r    <= 32'h0;
          lo_r    <= 32'h0;
          if (is_div) begin
            if (reg2_i != 32'h0) begin
              dvd   <= (is_signed && reg1_i[31]) ? (32'h0 - reg1_i) : reg1_i;
              dvs   <= (is_signed && reg2_i[31]) ? (32'h0 - reg2_i) : reg2_i;
              q_neg <= is_signed && (reg1_i[31] ^ reg2_i[31]);
              r_neg <= is_signed && reg1_i[31];
              rem   <= 32'h0;
              count <= 5'd0;
              state <= CALC;
            end else begin
              whilo_r <= 1'b1;
              hi_r    <= reg1_i;
              lo_r    <= 32'hFFFF_FFFF;
              state   <= DONE;
            end
          end
        end
        CALC: begin
          dvd   <= quo_next;
          rem   <= rem_next;
          count <= count + 5'd1;
          // Final step loads the sign-corrected results so DONE drives them from flops.
          if (count == 5'd31) begin
            whilo_r <= 1'b1;
            hi_r    <= rem_fix;
            lo_r    <= quo_fix;
            state   <= DONE;
          end
        end
        DONE: begin
          whilo_r <= 1'b0;
          hi_r    <= 32'h0;
          lo_r    <= 32'h0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign whilo_o    = rst ? 1'b0  : whilo_r;
  assign hi_o       = rst ? 32'h0 : hi_r;
  assign lo_o       = rst ? 32'h0 : lo_r;
  assign stallreq_o = !rst && is_div && ((state == IDLE) || (state == CALC));
`else
  logic unused_div;
  assign unused_div = &{1'b0, clk, flush_i};

  assign whilo_o    = 1'b0;
  assign hi_o       = 32'h0;
  assign lo_o       = 32'h0;
  assign stallreq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: table-driven logic/shift vectors plus hand-written
// divider sequences (divide checks only when DIV_EN is defined).
module tb_ex_unit;

  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  ex_unit dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wreg;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Watches for a stray HI/LO write after an aborted divide.
  task automatic checkQuiet(input string name, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (whilo_o || stallreq_o) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

`ifdef DIV_EN
  task automatic runDiv(input string name, input logic [7:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int bad = 0;
    @(negedge clk);
    applyStimulus(op, RES_NOP, r1, r2, 5'd0, 1'b0);
    for (int c = 0; c <= 32; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stallreq_o !== 1'b1 || whilo_o !== 1'b0) bad++;
    end
    checkOutput({name, "_stall_cycles0to32"}, bad, 0);
    @(negedge clk); #1;
    checkOutput({name, "_stall_done"}, {31'd0, stallreq_o}, 32'd0);
    checkOutput({name, "_whilo_done"}, {31'd0, whilo_o}, 32'd1);
    checkOutput({name, "_lo"}, lo_o, exp_lo);
    checkOutput({name, "_hi"}, hi_o, exp_hi);
    applyStimulus(EXE_NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk); #1;
    checkOutput({name, "_whilo_after"}, {31'd0, whilo_o}, 32'd0);
    checkOutput({name, "_lo_after"}, lo_o, 32'h0);
    checkOutput({name, "_hi_after"}, hi_o, 32'h0);
  endtask
`endif

  initial begin
    vecs[0]  = '{EXE_OR_OP,  RES_LOGIC, 32'h0000FF00, 32'h00F0000F, 5'd5,  1'b1, 32'h00F0FF0F};
    vecs[1]  = '{EXE_AND_OP, RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1,  1'b1, 32'h0F000F00};
    vecs[2]  = '{EXE_XOR_OP, RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd31, 1'b1, 32'hF0F00F0F};
    vecs[3]  = '{EXE_NOR_OP, RES_LOGIC, 32'h12340000, 32'h00005678, 5'd7,  1'b0, 32'hEDCBA987};
    vecs[4]  = '{EXE_SRA_OP, RES_SHIFT, 32'h00000004, 32'h80000000, 5'd2,  1'b1, 32'hF8000000};
    vecs[5]  = '{EXE_SRL_OP, RES_SHIFT, 32'h00000004, 32'h80000000, 5'd3,  1'b1, 32'h08000000};
    vecs[6]  = '{EXE_SLL_OP, RES_SHIFT, 32'hFFFFFFE4, 32'h0000000F, 5'd4,  1'b1, 32'h000000F0};
    vecs[7]  = '{EXE_SRA_OP, RES_SHIFT, 32'h0000001F, 32'h80000001, 5'd8,  1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{EXE_SRA_OP, RES_SHIFT, 32'h0000001F, 32'h7FFFFFFF, 5'd9,  1'b1, 32'h00000000};
    vecs[9]  = '{EXE_SLL_OP, RES_SHIFT, 32'h00000000, 32'hDEADBEEF, 5'd10, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{EXE_SLL_OP, RES_LOGIC, 32'h00000004, 32'h0000000F, 5'd11, 1'b1, 32'h00000000};
    vecs[11] = '{EXE_OR_OP,  RES_NOP,   32'h0000FF00, 32'h00F0000F, 5'd12, 1'b1, 32'h00000000};

    rst     = 1'b1;
    flush_i = 1'b0;
    applyStimulus(EXE_OR_OP, RES_LOGIC, 32'h0000FF00, 32'h00F0000F, 5'd5, 1'b1);
    @(negedge clk); @(negedge clk); #1;
    checkOutput("reset_wdata", wdata_o, 32'h0);
    checkOutput("reset_wd", {27'd0, wd_o}, 32'd0);
    checkOutput("reset_wreg", {31'd0, wreg_o}, 32'd0);
    checkOutput("reset_whilo", {31'd0, whilo_o}, 32'd0);
    checkOutput("reset_hi", hi_o, 32'h0);
    checkOutput("reset_lo", lo_o, 32'h0);
    checkOutput("reset_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].aluop, vecs[i].alusel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
      #1;
      checkOutput($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp_wdata);
      checkOutput($sformatf("vec%0d_wd", i), {27'd0, wd_o}, {27'd0, vecs[i].wd});
      checkOutput($sformatf("vec%0d_wreg", i), {31'd0, wreg_o}, {31'd0, vecs[i].wreg});
    end

`ifdef DIV_EN
    runDiv("div_neg7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    runDiv("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2);
    runDiv("div_100_neg7", EXE_DIV_OP, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    runDiv("divu_big", EXE_DIVU_OP, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F);

    // Divide by zero finishes one cycle after issue.
    @(negedge clk);
    applyStimulus(EXE_DIVU_OP, RES_NOP, 32'h12345678, 32'h0, 5'd0, 1'b0);
    #1;
    checkOutput("div0_stall_issue", {31'd0, stallreq_o}, 32'd1);
    @(negedge clk); #1;
    checkOutput("div0_whilo", {31'd0, whilo_o}, 32'd1);
    checkOutput("div0_lo", lo_o, 32'hFFFFFFFF);
    checkOutput("div0_hi", hi_o, 32'h12345678);
    checkOutput("div0_stall_done", {31'd0, stallreq_o}, 32'd0);
    applyStimulus(EXE_NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk); #1;
    checkOutput("div0_whilo_after", {31'd0, whilo_o}, 32'd0);

    // Flush during CALC cycle 10: the divide must never complete.
    @(negedge clk);
    applyStimulus(EXE_DIVU_OP, RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_stall_before", {31'd0, stallreq_o}, 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    applyStimulus(EXE_NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    checkOutput("flush_stall_after", {31'd0, stallreq_o}, 32'd0);
    checkQuiet("flush_no_whilo", 40);

    // Reset pulse mid-CALC forces every output to 0 and abandons the divide.
    @(negedge clk);
    applyStimulus(EXE_DIV_OP, RES_NOP, 32'hFFFFFFF9, 32'd2, 5'd3, 1'b0);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_stall", {31'd0, stallreq_o}, 32'd0);
    checkOutput("rstmid_wd", {27'd0, wd_o}, 32'd0);
    checkOutput("rstmid_lo", lo_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(EXE_NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    checkQuiet("rstmid_no_whilo", 40);
`else
    // Without the divider, divide ops behave as NOPs and the HI/LO side stays at 0.
    @(negedge clk);
    applyStimulus(EXE_DIV_OP, RES_NOP, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    #1;
    checkOutput("nodiv_wdata", wdata_o, 32'h0);
    checkOutput("nodiv_stall", {31'd0, stallreq_o}, 32'd0);
    checkQuiet("nodiv_quiet", 40);
    checkOutput("nodiv_hi", hi_o, 32'h0);
    checkOutput("nodiv_lo", lo_o, 32'h0);
    applyStimulus(EXE_NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
